axi4_lite_cmd_mst: RTL and testbench

AXI4_LITE_CMD_MST -- requirements
Module: axi4_lite_cmd_mst

---
 rtl/axi4_lite_cmd_mst_pkg.sv | 42 ++++
 rtl/axi4_lite_if_pkg.sv | 12 +
 rtl/axi4_lite_if.sv | 53 +++++
 rtl/axi4_lite_cmd_mst.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_cmd_mst.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_lite_cmd_mst_pkg.sv
// Types shared by the AXI4-Lite command master.
// Command fields are held at maximum width and sliced by the user.
package axi4_lite_cmd_mst_pkg;

  import axi4_lite_if_pkg::*;

  localparam int CMD_ADDR_MAX_W = 64;
  localparam int CMD_DATA_MAX_W = 64;
  localparam int CMD_STRB_MAX_W = CMD_DATA_MAX_W / 8;

  localparam logic [15:0] ERR_CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } state_e;

  typedef struct packed {
    logic                      is_wr;
    logic [CMD_ADDR_MAX_W-1:0] addr;
    logic [CMD_DATA_MAX_W-1:0] wdata;
    logic [CMD_STRB_MAX_W-1:0] wstrb;
  } cmd_t;

  // Saturating error count update for one captured response.
  function automatic logic [15:0] err_cnt_next(
    input logic [15:0] cnt,
    input logic [1:0]  resp
  );
    logic [15:0] nxt;
    nxt = cnt;
    if (resp != AXI4_LITE_RESP_OKAY && cnt != ERR_CNT_MAX) begin
      nxt = cnt + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/axi4_lite_if_pkg.sv
// Shared AXI4-Lite constants.
// Response encodings used by every AXI4-Lite block.
package axi4_lite_if_pkg;

  localparam logic [1:0] AXI4_LITE_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI4_LITE_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI4_LITE_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI4_LITE_RESP_DECERR = 2'b11;

  localparam int AXI4_LITE_PROT_W = 3;

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with master and slave views.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport mst_port (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slv_port (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_cmd_mst.sv
// AXI4-Lite command master: one command in, one AXI4-Lite
// transaction out, one registered response back.
module axi4_lite_cmd_mst
  import axi4_lite_if_pkg::*;
  import axi4_lite_cmd_mst_pkg::*;
#(
  parameter int AXI4_LITE_ADDR_BIT_WIDTH = 32,
  parameter int AXI4_LITE_DATA_BIT_WIDTH = 32
) (
  input  logic                                  i_clk,
  input  logic                                  i_async_rst,
  input  logic                                  i_cmd_valid,
  output logic                                  o_cmd_ready,
  input  logic                                  i_cmd_is_wr,
  input  logic [AXI4_LITE_ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
  input  logic [AXI4_LITE_DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
  output logic                                  o_rsp_valid,
  input  logic                                  i_rsp_ready,
  output logic [AXI4_LITE_DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
  output logic [1:0]                            o_rsp_resp,
  output logic [15:0]                           o_err_cnt,
  axi4_lite_if.mst_port                         if_m_axi4_lite
);

  localparam int AW = AXI4_LITE_ADDR_BIT_WIDTH;
  localparam int DW = AXI4_LITE_DATA_BIT_WIDTH;
  localparam int SW = DW / 8;

  state_e          state_q, state_d;
  cmd_t            cmd_q, cmd_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d;
  logic            wvalid_q, wvalid_d;
  logic            bready_q, bready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic [15:0]     err_q, err_d;
  logic            cap;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    err_d       = err_q;
    cap         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_cmd_valid && cmd_ready_q) begin
          cmd_d.is_wr = i_cmd_is_wr;
          cmd_d.addr  = CMD_ADDR_MAX_W'(i_cmd_addr);
          cmd_d.wdata = CMD_DATA_MAX_W'(i_cmd_wdata);
          cmd_d.wstrb = CMD_STRB_MAX_W'(i_cmd_wstrb);
          if (i_cmd_is_wr) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W retire independently; leave once both are gone.
        if (awvalid_q && if_m_axi4_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && if_m_axi4_lite.wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_B;
          bready_d = 1'b1;
        end
      end
      WR_B: begin
        if (bready_q && if_m_axi4_lite.bvalid) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = if_m_axi4_lite.bresp;
          rsp_valid_d = 1'b1;
          cap         = 1'b1;
        end
      end
      RD_AR: begin
        if (arvalid_q && if_m_axi4_lite.arready) begin
          state_d   = RD_R;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_R: begin
        if (rready_q && if_m_axi4_lite.rvalid) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rdata_d     = if_m_axi4_lite.rdata;
          resp_d      = if_m_axi4_lite.rresp;
          rsp_valid_d = 1'b1;
          cap         = 1'b1;
        end
      end
      RSP: begin
        if (i_rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cap) err_d = err_cnt_next(err_q, resp_d);

    // Registered ready: high exactly while the next state is IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      resp_q      <= AXI4_LITE_RESP_OKAY;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  assign o_cmd_ready = cmd_ready_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;
  assign o_err_cnt   = err_q;

  assign if_m_axi4_lite.awaddr  = cmd_q.addr[AW-1:0];
  assign if_m_axi4_lite.awprot  = '0;
  assign if_m_axi4_lite.awvalid = awvalid_q;
  assign if_m_axi4_lite.wdata   = cmd_q.wdata[DW-1:0];
  assign if_m_axi4_lite.wstrb   = cmd_q.wstrb[SW-1:0];
  assign if_m_axi4_lite.wvalid  = wvalid_q;
  assign if_m_axi4_lite.bready  = bready_q;
  assign if_m_axi4_lite.araddr  = cmd_q.addr[AW-1:0];
  assign if_m_axi4_lite.arprot  = '0;
  assign if_m_axi4_lite.arvalid = arvalid_q;
  assign if_m_axi4_lite.rready  = rready_q;

  // Upper command bits exist only for wider configurations.
  logic unused_cmd;
  assign unused_cmd = ^{cmd_q.is_wr, cmd_q};

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Directed bench for axi4_lite_cmd_mst with an in-bench
// 4-register slave that has programmable ready delays and resp.
module tb_axi4_lite_cmd_mst;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_is_wr = 1'b0;
  logic [31:0] i_cmd_addr = '0;
  logic [31:0] i_cmd_wdata = '0;
  logic [3:0]  i_cmd_wstrb = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic [1:0]  o_rsp_resp;
  logic [15:0] o_err_cnt;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_lite_cmd_mst #(
    .AXI4_LITE_ADDR_BIT_WIDTH(32),
    .AXI4_LITE_DATA_BIT_WIDTH(32)
  ) dut (
    .i_clk          (clk),
    .i_async_rst    (rst),
    .i_cmd_valid    (i_cmd_valid),
    .o_cmd_ready    (o_cmd_ready),
    .i_cmd_is_wr    (i_cmd_is_wr),
    .i_cmd_addr     (i_cmd_addr),
    .i_cmd_wdata    (i_cmd_wdata),
    .i_cmd_wstrb    (i_cmd_wstrb),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (i_rsp_ready),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_resp     (o_rsp_resp),
    .o_err_cnt      (o_err_cnt),
    .if_m_axi4_lite (axi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave model
  logic [31:0] regs [4];
  logic [1:0]  slv_resp = 2'b00;
  int          aw_wait = 0;
  int          w_wait = 0;
  int          aw_cnt, w_cnt;
  int          aw_hs = 0;
  int          w_hs = 0;
  logic        aw_got, w_got;
  logic [31:0] aw_a, w_d;
  logic [3:0]  w_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      axi.awready <= 1'b0;
      axi.wready  <= 1'b0;
      axi.bvalid  <= 1'b0;
      axi.bresp   <= 2'b00;
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= 2'b00;
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      aw_cnt      <= 0;
      w_cnt       <= 0;
    end else begin
      if (axi.awvalid && axi.awready) begin
        aw_got      <= 1'b1;
        aw_a        <= axi.awaddr;
        axi.awready <= 1'b0;
        aw_cnt      <= 0;
        aw_hs       <= aw_hs + 1;
      end else if (axi.awvalid && !aw_got) begin
        if (aw_cnt >= aw_wait) axi.awready <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (axi.wvalid && axi.wready) begin
        w_got      <= 1'b1;
        w_d        <= axi.wdata;
        w_s        <= axi.wstrb;
        axi.wready <= 1'b0;
        w_cnt      <= 0;
        w_hs       <= w_hs + 1;
      end else if (axi.wvalid && !w_got) begin
        if (w_cnt >= w_wait) axi.wready <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (aw_got && w_got && !axi.bvalid) begin
        for (int b = 0; b < 4; b++) begin
          if (w_s[b]) regs[aw_a[3:2]][b*8 +: 8] <= w_d[b*8 +: 8];
        end
        axi.bvalid <= 1'b1;
        axi.bresp  <= slv_resp;
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
      end else if (axi.bvalid && axi.bready) begin
        axi.bvalid <= 1'b0;
      end
      if (axi.arvalid && axi.arready) begin
        axi.arready <= 1'b0;
        axi.rvalid  <= 1'b1;
        axi.rdata   <= regs[axi.araddr[3:2]];
        axi.rresp   <= slv_resp;
      end else if (axi.arvalid && !axi.rvalid) begin
        axi.arready <= 1'b1;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  // Handshake-ordering monitor
  logic mon_en = 1'b0;
  int   hs_aw0 = 0;
  int   hs_w0 = 0;
  int   aw_only = 0;
  int   w_late = 0;
  int   b_early = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (axi.awvalid && !axi.wvalid) aw_only++;
      if (axi.wvalid && w_hs != hs_w0) w_late++;
      if (axi.bready && (aw_hs == hs_aw0 || w_hs == hs_w0)) b_early++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_is_wr = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = d;
    i_cmd_wstrb = s;
    while (!o_cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'd0, o_cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic [1:0] r);
    int n;
    n = 0;
    while (!o_rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid_wait", {31'd0, o_rsp_valid}, 32'd1);
    d = o_rsp_rdata;
    r = o_rsp_resp;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    i_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [1:0]  rr;
  int          bad;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_err_cnt", {16'd0, o_err_cnt}, 32'd0);
    chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready,
        axi.arvalid, axi.rready}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready_pre", {31'd0, o_cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rel_no_valid", {30'd0, axi.awvalid, axi.arvalid}, 32'd0);

    // Write then read back
    send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    chk("wr_aw_w_vld", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    chk("wr_awaddr", axi.awaddr, 32'h4);
    chk("wr_wdata", axi.wdata, 32'hDEADBEEF);
    chk("wr_wstrb", {28'd0, axi.wstrb}, 32'hF);
    chk("wr_no_ar", {31'd0, axi.arvalid}, 32'd0);
    get_rsp(rd, rr);
    chk("wr_resp", {30'd0, rr}, 32'd0);
    chk("wr_rdata", rd, 32'd0);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    chk("rd_ar_vld", {30'd0, axi.arvalid, axi.awvalid}, 32'd2);
    chk("rd_araddr", axi.araddr, 32'h4);
    get_rsp(rd, rr);
    chk("rd_rdata", rd, 32'hDEADBEEF);
    chk("rd_resp", {30'd0, rr}, 32'd0);

    // Partial strobe
    send_cmd(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF);
    get_rsp(rd, rr);
    send_cmd(1'b1, 32'h8, 32'h00000000, 4'h5);
    get_rsp(rd, rr);
    send_cmd(1'b0, 32'h8, 32'h0, 4'h0);
    get_rsp(rd, rr);
    chk("strb_rdata", rd, 32'hFF00FF00);

    // WREADY three cycles ahead of AWREADY
    aw_wait = 3;
    w_wait  = 0;
    hs_aw0  = aw_hs;
    hs_w0   = w_hs;
    aw_only = 0;
    w_late  = 0;
    b_early = 0;
    mon_en  = 1'b1;
    send_cmd(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF);
    get_rsp(rd, rr);
    mon_en  = 1'b0;
    aw_wait = 0;
    chk("skew_aw_hs", aw_hs - hs_aw0, 32'd1);
    chk("skew_w_hs", w_hs - hs_w0, 32'd1);
    chk("skew_aw_only", aw_only, 32'd3);
    chk("skew_w_late", w_late, 32'd0);
    chk("skew_b_early", b_early, 32'd0);
    chk("skew_resp", {30'd0, rr}, 32'd0);

    // SLVERR counting and saturation
    slv_resp = 2'b10;
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
      get_rsp(rd, rr);
      chk("err_resp", {30'd0, rr}, 32'h2);
    end
    chk("err_cnt3", {16'd0, o_err_cnt}, 32'd3);
    force dut.err_q = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.err_q;
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    get_rsp(rd, rr);
    chk("sat_resp", {30'd0, rr}, 32'h2);
    chk("sat_err_cnt", {16'd0, o_err_cnt}, 32'hFFFF);
    slv_resp = 2'b00;

    // Response backpressure, then back-to-back command
    send_cmd(1'b1, 32'hC, 32'h12345678, 4'hF);
    bad = 0;
    while (!o_rsp_valid && bad < 100) begin
      @(negedge clk);
      bad++;
    end
    chk("bp_rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_is_wr = 1'b0;
    i_cmd_addr  = 32'hC;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!o_rsp_valid || o_rsp_rdata !== 32'd0 ||
          o_rsp_resp !== 2'b00 || o_cmd_ready) bad++;
    end
    chk("bp_stable", bad, 32'd0);
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_rsp_done", {31'd0, o_rsp_valid}, 32'd0);
    chk("b2b_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_accepted", {30'd0, o_cmd_ready, axi.arvalid}, 32'd1);
    chk("b2b_araddr", axi.araddr, 32'hC);
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b0;
    get_rsp(rd, rr);
    chk("b2b_rdata", rd, 32'h12345678);

    // Reset in the middle of a write
    aw_wait = 10;
    send_cmd(1'b1, 32'h0, 32'h11111111, 4'hF);
    @(negedge clk);
    chk("mid_awvalid", {31'd0, axi.awvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready,
        axi.arvalid, axi.rready}, 32'd0);
    chk("mid_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
    chk("mid_err_cnt", {16'd0, o_err_cnt}, 32'd0);
    chk("mid_awaddr_wdata", axi.awaddr | axi.wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    aw_wait = 0;
    @(posedge clk);
    #1;
    chk("mid_rel_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("mid_rel_noval", {31'd0, axi.awvalid}, 32'd0);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    get_rsp(rd, rr);
    chk("post_rst_rdata", rd, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
